// File: rtl/morph_pkg.sv
// Shared types and constants for the 3x3 binary morphology stage.
package morph_pkg;

  typedef enum logic [1:0] {
    MORPH_PASS     = 2'd0,
    MORPH_ERODE    = 2'd1,
    MORPH_DILATE   = 2'd2,
    MORPH_MAJORITY = 2'd3
  } morph_mode_t;

  localparam int MORPH_MAJ_THRESH = 5;

endpackage

// File: rtl/popcount9.sv
// Combinational population count of a 3x3 binary window.
module popcount9 (
  input  logic [8:0] bits_in,
  output logic [3:0] count_out
);

  always_comb begin
    count_out = 4'd0;
    for (int i = 0; i < 9; i++) begin
      count_out = count_out + {3'd0, bits_in[i]};
    end
  end

endmodule

// File: rtl/binary_morph_3x3.sv
// Streaming 3x3 binary morphology (pass/erode/dilate/majority) with a
// per-frame count of set output pixels.
module binary_morph_3x3
  import morph_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [2:0]  col_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic [1:0]  mode_in,
  output logic        pixel_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out,
  output logic [16:0] ones_count_out,
  output logic        frame_done_out
);

  // Stream contract: a column is taken on every cycle data_valid_in is high;
  // there is no ready, and each output is qualified by data_valid_out alone.
  localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
  localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

  logic [2:0]  w0, w1, w2;
  logic        line_ok;
  logic        flush_pending;
  logic        s1_emit, s1_flush, s1_flush_bit, s1_latch;
  logic [10:0] s1_h;
  logic [9:0]  s1_v;
  morph_mode_t s1_mode_next, mode_q;
  logic        frame_ok;
  logic [16:0] acc;

  logic        in_start, in_emit, frame_start;
  logic [8:0]  win;
  logic [3:0]  pop;
  logic        border, op_bit, result, last_px;

  assign in_start    = data_valid_in && (hcount_in == 11'd0);
  assign in_emit     = data_valid_in && (hcount_in != 11'd0) && line_ok;
  assign frame_start = in_start && (vcount_in == 10'd0);

  // Stage 1: window shift and output coordinates. A flush slot reuses the
  // previous line's vcount and snapshots the last column's centre bit,
  // because a hcount-0 column may shift the window in the same cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      w0            <= 3'd0;
      w1            <= 3'd0;
      w2            <= 3'd0;
      line_ok       <= 1'b0;
      flush_pending <= 1'b0;
      s1_emit       <= 1'b0;
      s1_flush      <= 1'b0;
      s1_flush_bit  <= 1'b0;
      s1_latch      <= 1'b0;
      s1_h          <= 11'd0;
      s1_v          <= 10'd0;
      s1_mode_next  <= MORPH_PASS;
    end else begin
      if (data_valid_in) begin
        w2 <= w1;
        w1 <= w0;
        w0 <= col_in;
      end
      if (in_start) line_ok <= 1'b1;
      flush_pending <= in_emit && (hcount_in == H_LAST);
      s1_flush      <= flush_pending;
      s1_flush_bit  <= w0[1];
      s1_latch      <= frame_start;
      if (frame_start) s1_mode_next <= morph_mode_t'(mode_in);
      if (flush_pending) begin
        s1_emit <= 1'b1;
        s1_h    <= H_LAST;
      end else begin
        s1_emit <= in_emit;
        if (in_emit) begin
          s1_h <= hcount_in - 11'd1;
          s1_v <= vcount_in;
        end
      end
    end
  end

  assign win = {w2, w1, w0};

  popcount9 u_popcount9 (
    .bits_in   (win),
    .count_out (pop)
  );

  assign border  = (s1_h == 11'd0) || (s1_h == H_LAST) ||
                   (s1_v == 10'd0) || (s1_v == V_LAST);
  assign last_px = s1_emit && (s1_h == H_LAST) && (s1_v == V_LAST);

  always_comb begin
    op_bit = 1'b0;
    case (mode_q)
      MORPH_PASS:     op_bit = w1[1];
      MORPH_ERODE:    op_bit = &win;
      MORPH_DILATE:   op_bit = |win;
      MORPH_MAJORITY: op_bit = (pop >= 4'(MORPH_MAJ_THRESH));
      default:        op_bit = 1'b0;
    endcase
  end

  always_comb begin
    result = op_bit;
    if (s1_flush) begin
      result = (mode_q == MORPH_PASS) ? s1_flush_bit : 1'b0;
    end else if (border && (mode_q != MORPH_PASS)) begin
      result = 1'b0;
    end
  end

  // Stage 2: result register and frame counter. The mode latch is applied
  // here so the last pixels of a back-to-back previous frame keep their mode.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out      <= 1'b0;
      hcount_out     <= 11'd0;
      vcount_out     <= 10'd0;
      data_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      ones_count_out <= 17'd0;
      acc            <= 17'd0;
      mode_q         <= MORPH_PASS;
      frame_ok       <= 1'b0;
    end else begin
      data_valid_out <= s1_emit;
      frame_done_out <= 1'b0;
      if (s1_emit) begin
        pixel_out  <= result;
        hcount_out <= s1_h;
        vcount_out <= s1_v;
      end
      if (last_px && frame_ok) begin
        ones_count_out <= acc + {16'd0, result};
        frame_done_out <= 1'b1;
      end
      if (s1_latch || last_px) begin
        acc <= 17'd0;
      end else if (s1_emit && result) begin
        acc <= acc + 17'd1;
      end
      if (s1_latch) begin
        mode_q   <= s1_mode_next;
        frame_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_binary_morph_3x3.sv
// Directed frames through binary_morph_3x3 (24x16) with a queue scoreboard
// on pixels and per-frame counts.
module tb_binary_morph_3x3;
  import morph_pkg::*;

  localparam int W = 24;
  localparam int H = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [2:0]  col_in = 3'd0;
  logic [10:0] hcount_in = 11'd0;
  logic [9:0]  vcount_in = 10'd0;
  logic        data_valid_in = 1'b0;
  logic [1:0]  mode_in = 2'd0;
  logic        pixel_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;
  logic [16:0] ones_count_out;
  logic        frame_done_out;

  binary_morph_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .col_in         (col_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .mode_in        (mode_in),
    .pixel_out      (pixel_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .data_valid_out (data_valid_out),
    .ones_count_out (ones_count_out),
    .frame_done_out (frame_done_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [21:0] exp_q[$];
  int          exp_t_q[$];
  logic [16:0] cnt_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          img [0:H-1][0:W-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // image helpers and reference model
  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  task automatic fill_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b1;
  endtask

  task automatic set_block(input int cx, input int cy);
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) img[cy+dy][cx+dx] = 1'b1;
  endtask

  task automatic set_majority_pattern();
    clear_img();
    img[4][4] = 1; img[4][5] = 1; img[4][6] = 1; img[5][4] = 1; img[5][5] = 1;
    img[9][15] = 1; img[9][16] = 1; img[10][15] = 1; img[10][16] = 1;
  endtask

  function automatic bit model_pix(input morph_mode_t m, input int x, input int y);
    int n;
    bit a, o;
    n = 0; a = 1'b1; o = 1'b0;
    if (m == MORPH_PASS) return img[y][x];
    if (x == 0 || x == W-1 || y == 0 || y == H-1) return 1'b0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        n += int'(img[y+dy][x+dx]);
        a &= img[y+dy][x+dx];
        o |= img[y+dy][x+dx];
      end
    case (m)
      MORPH_ERODE:  return a;
      MORPH_DILATE: return o;
      default:      return n >= 5;
    endcase
  endfunction

  function automatic logic [2:0] col_at(input int x, input int y);
    logic t, b;
    t = (y > 0)   ? img[y-1][x] : 1'b0;
    b = (y < H-1) ? img[y+1][x] : 1'b0;
    return {t, img[y][x], b};
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      data_valid_in = 1'b0;
    end
  endtask

  task automatic drive_col(input int x, input int y, input logic [1:0] mv,
                           input morph_mode_t me, input bit emit_ok);
    @(posedge clk_in); #1;
    data_valid_in = 1'b1;
    col_in        = col_at(x, y);
    hcount_in     = 11'(x);
    vcount_in     = 10'(y);
    mode_in       = mv;
    if (emit_ok && x >= 1) begin
      exp_q.push_back({model_pix(me, x-1, y), 11'(x-1), 10'(y)});
      exp_t_q.push_back(cyc + 2);
    end
    if (emit_ok && x == W-1) begin
      exp_q.push_back({model_pix(me, W-1, y), 11'(W-1), 10'(y)});
      exp_t_q.push_back(cyc + 3);
    end
  endtask

  task automatic drive_frame(input morph_mode_t m_exp, input logic [1:0] m_in,
                             input logic [1:0] m_late, input int chg_h, input int chg_v,
                             input int start_v, input int start_h, input int emit_v,
                             input int stop_v, input int stop_h, input int last_gap);
    for (int y = start_v; y < H; y++) begin
      for (int x = (y == start_v) ? start_h : 0; x < W; x++) begin
        drive_col(x, y, (y > chg_v || (y == chg_v && x >= chg_h)) ? m_late : m_in,
                  m_exp, y >= emit_v);
        if (y == stop_v && x == stop_h) return;
        if (x == 7 && y % 4 == 1) idle(1);
      end
      idle((y == H-1) ? last_gap : y % 3);
    end
  endtask

  task automatic frame(input morph_mode_t m, input int last_gap);
    drive_frame(m, m, m, 0, H, 0, 0, 0, H, 0, last_gap);
  endtask

  // monitor
  always @(negedge clk_in) begin
    logic [21:0] e;
    int t;
    if (frame_done_out) begin
      if (cnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_done_unexpected at cycle %0d: count %0d", cyc, ones_count_out);
      end else begin
        check("ones_count", 32'(ones_count_out), 32'(cnt_q.pop_front()));
        check("frame_done_pos", {data_valid_out, hcount_out, vcount_out},
              {1'b1, 11'(W-1), 10'(H-1)});
      end
    end
    if (data_valid_out) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pixel_unexpected at cycle %0d: h=%0d v=%0d p=%0b",
                 cyc, hcount_out, vcount_out, pixel_out);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("pixel_pv_h_v", {pixel_out, hcount_out, vcount_out}, e);
        check("pixel_cycle", 32'(cyc), 32'(t));
      end
    end
  end

  // stimulus
  initial begin
    #2 rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_pixel", 32'(pixel_out), 0);
    check("rst_hv", {hcount_out, vcount_out}, 0);
    check("rst_valid", 32'(data_valid_out), 0);
    check("rst_done", 32'(frame_done_out), 0);
    check("rst_count", 32'(ones_count_out), 0);
    rst_in = 1'b0;

    clear_img(); img[5][10] = 1'b1;
    cnt_q.push_back(17'd1);
    frame(MORPH_PASS, 2);

    clear_img(); set_block(8, 6);
    cnt_q.push_back(17'd1);
    frame(MORPH_ERODE, 2);
    cnt_q.push_back(17'd25);
    frame(MORPH_DILATE, 0);

    set_majority_pattern();
    cnt_q.push_back(17'd2);
    frame(MORPH_MAJORITY, 2);

    fill_img();
    cnt_q.push_back(17'(22 * 14));
    frame(MORPH_MAJORITY, 2);

    // mode request changes mid-frame; erode must hold for the whole frame
    clear_img(); set_block(15, 11);
    cnt_q.push_back(17'd1);
    drive_frame(MORPH_ERODE, MORPH_ERODE, MORPH_DILATE, 12, 8, 0, 0, 0, H, 0, 0);
    cnt_q.push_back(17'd25);
    frame(MORPH_DILATE, 2);

    // asynchronous reset in the middle of line 6
    clear_img(); set_block(8, 6); img[9][3] = 1'b1; img[12][20] = 1'b1;
    drive_frame(MORPH_ERODE, MORPH_ERODE, MORPH_ERODE, 0, H, 0, 0, 0, 6, 15, 0);
    @(posedge clk_in); #3;
    rst_in = 1'b1;
    data_valid_in = 1'b0;
    #1;
    check("arst_valid", 32'(data_valid_out), 0);
    check("arst_pixel", 32'(pixel_out), 0);
    check("arst_hv", {hcount_out, vcount_out}, 0);
    check("arst_count", 32'(ones_count_out), 0);
    exp_q.delete();
    exp_t_q.delete();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    drive_frame(MORPH_PASS, MORPH_ERODE, MORPH_ERODE, 0, H, 6, 16, 7, H, 0, 3);
    idle(4);
    check("count_after_partial", 32'(ones_count_out), 0);

    set_majority_pattern();
    cnt_q.push_back(17'd2);
    frame(MORPH_MAJORITY, 6);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("cnt_q_drained", 32'(cnt_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
